// File: rtl/regfile_sb_param.sv
// rtl/regfile_sb_param.sv - register file with byte-masked writes, write-to-read bypass and busy scoreboard
module regfile_sb_param #(
   parameter int DW       = 64,
   parameter int NREGS    = 32,
   parameter int AW       = $clog2(NREGS),
   parameter bit ZERO_REG = 1'b1
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            WE,
   input  logic [AW-1:0]   W_ADDR,
   input  logic [DW-1:0]   W_DATA,
   input  logic [DW/8-1:0] W_MASK,
   input  logic [AW-1:0]   R_ADDR1,
   input  logic [AW-1:0]   R_ADDR2,
   output logic [DW-1:0]   OUT1,
   output logic [DW-1:0]   OUT2,
   output logic            BUSY1,
   output logic            BUSY2,
   input  logic            ISSUE_VLD,
   input  logic [AW-1:0]   ISSUE_ADDR,
   input  logic            FLUSH
);
   localparam int NB = DW / 8;

   // Storage is deliberately not reset; valid gates it so reset takes one edge.
   logic [DW-1:0]    mem [NREGS];
   logic [NREGS-1:0] valid;
   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_nxt;
   logic             w_legal;
   logic             issue_legal;
   logic [DW-1:0]    w_old;
   logic [DW-1:0]    w_merged;

   // Address that maps onto real, writable storage (in range and not the zero register).
   function automatic logic is_real(input logic [AW-1:0] a);
      return (32'(a) < NREGS) && !(ZERO_REG && (a == '0));
   endfunction

   // Architectural value of a register: invalid or non-real registers read as zero.
   function automatic logic [DW-1:0] stored(input logic [AW-1:0] a);
      if (is_real(a) && valid[a]) begin
         return mem[a];
      end
      return '0;
   endfunction

   // Post-edge value of the write target: masked bytes from W_DATA, the rest from the stored value.
   always_comb begin
      w_legal     = WE && is_real(W_ADDR);
      issue_legal = ISSUE_VLD && is_real(ISSUE_ADDR);
      w_old       = stored(W_ADDR);
      w_merged    = w_old;
      for (int i = 0; i < NB; i++) begin
         if (W_MASK[i]) begin
            w_merged[8*i +: 8] = W_DATA[8*i +: 8];
         end
      end
   end

   // Zero-latency reads with writeback bypass; everything reads zero while held in reset.
   always_comb begin
      OUT1  = '0;
      OUT2  = '0;
      BUSY1 = 1'b0;
      BUSY2 = 1'b0;
      if (RST_N) begin
         OUT1  = (w_legal && (W_ADDR == R_ADDR1)) ? w_merged : stored(R_ADDR1);
         OUT2  = (w_legal && (W_ADDR == R_ADDR2)) ? w_merged : stored(R_ADDR2);
         BUSY1 = is_real(R_ADDR1) && busy[R_ADDR1] &&
                 !(w_legal && (W_ADDR == R_ADDR1)) && !FLUSH;
         BUSY2 = is_real(R_ADDR2) && busy[R_ADDR2] &&
                 !(w_legal && (W_ADDR == R_ADDR2)) && !FLUSH;
      end
   end

   // Scoreboard next state: writeback clears, a newer issue re-sets, flush wipes everything.
   always_comb begin
      busy_nxt = busy;
      if (w_legal) begin
         busy_nxt[W_ADDR] = 1'b0;
      end
      if (issue_legal) begin
         busy_nxt[ISSUE_ADDR] = 1'b1;
      end
      if (FLUSH) begin
         busy_nxt = '0;
      end
   end

   // Data array update; only the merged value is ever written.
   always_ff @(posedge CLK) begin
      if (w_legal) begin
         mem[W_ADDR] <= w_merged;
      end
   end

   // Valid and busy bits clear asynchronously so reset empties the file at once.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         valid <= '0;
         busy  <= '0;
      end else begin
         if (w_legal) begin
            valid[W_ADDR] <= 1'b1;
         end
         busy <= busy_nxt;
      end
   end
endmodule

// File: tb/tb_regfile_sb_param.sv
// tb/tb_regfile_sb_param.sv - self-checking bench for regfile_sb_param (32x64 and 20x32 instances)
module tb_regfile_sb_param;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        we;
   logic [4:0]  waddr;
   logic [63:0] wdata;
   logic [7:0]  wmask;
   logic [4:0]  r1;
   logic [4:0]  r2;
   logic        iv;
   logic [4:0]  ia;
   logic        flush;
   logic [63:0] a_out1, a_out2;
   logic [31:0] b_out1, b_out2;
   logic        a_b1, a_b2, b_b1, b_b2;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: architectural value (0 when never written) and pending flag per register.
   logic [63:0] ref_val  [2][32];
   bit          ref_busy [2][32];

   always #5 clk = ~clk;

   regfile_sb_param #(.DW(64), .NREGS(32), .ZERO_REG(1'b1)) u_a (
      .CLK(clk), .RST_N(rst_n), .WE(we), .W_ADDR(waddr), .W_DATA(wdata), .W_MASK(wmask),
      .R_ADDR1(r1), .R_ADDR2(r2), .OUT1(a_out1), .OUT2(a_out2), .BUSY1(a_b1), .BUSY2(a_b2),
      .ISSUE_VLD(iv), .ISSUE_ADDR(ia), .FLUSH(flush)
   );

   regfile_sb_param #(.DW(32), .NREGS(20), .ZERO_REG(1'b1)) u_b (
      .CLK(clk), .RST_N(rst_n), .WE(we), .W_ADDR(waddr), .W_DATA(wdata[31:0]), .W_MASK(wmask[3:0]),
      .R_ADDR1(r1), .R_ADDR2(r2), .OUT1(b_out1), .OUT2(b_out2), .BUSY1(b_b1), .BUSY2(b_b2),
      .ISSUE_VLD(iv), .ISSUE_ADDR(ia), .FLUSH(flush)
   );

   function automatic int nregs(input int d);
      return (d == 0) ? 32 : 20;
   endfunction

   function automatic int nbytes(input int d);
      return (d == 0) ? 8 : 4;
   endfunction

   function automatic bit is_real(input int d, input int a);
      return (a < nregs(d)) && (a != 0);
   endfunction

   function automatic logic [63:0] merge(input int d, input logic [63:0] old,
                                         input logic [63:0] data, input logic [7:0] mask);
      logic [63:0] r;
      r = old;
      for (int i = 0; i < nbytes(d); i++) begin
         if (mask[i]) r[8*i +: 8] = data[8*i +: 8];
      end
      return r;
   endfunction

   function automatic logic [63:0] exp_out(input int d, input int r);
      if (!rst_n) return 64'd0;
      if (we && is_real(d, int'(waddr)) && (int'(waddr) == r))
         return merge(d, ref_val[d][r], wdata, wmask);
      return is_real(d, r) ? ref_val[d][r] : 64'd0;
   endfunction

   function automatic logic exp_busy(input int d, input int r);
      if (!rst_n || flush) return 1'b0;
      if (we && is_real(d, int'(waddr)) && (int'(waddr) == r)) return 1'b0;
      return is_real(d, r) && ref_busy[d][r];
   endfunction

   task automatic model_clear();
      for (int d = 0; d < 2; d++) begin
         for (int a = 0; a < 32; a++) begin
            ref_val[d][a]  = 64'd0;
            ref_busy[d][a] = 1'b0;
         end
      end
   endtask

   task automatic model_edge();
      if (!rst_n) return;
      for (int d = 0; d < 2; d++) begin
         if (we && is_real(d, int'(waddr)))
            ref_val[d][waddr] = merge(d, ref_val[d][waddr], wdata, wmask);
         if (flush) begin
            for (int a = 0; a < 32; a++) ref_busy[d][a] = 1'b0;
         end else begin
            if (we && is_real(d, int'(waddr))) ref_busy[d][waddr] = 1'b0;
            if (iv && is_real(d, int'(ia))) ref_busy[d][ia] = 1'b1;
         end
      end
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "_a_out1"}, a_out1, exp_out(0, int'(r1)));
      check({tag, "_a_out2"}, a_out2, exp_out(0, int'(r2)));
      check({tag, "_a_busy1"}, {63'd0, a_b1}, {63'd0, exp_busy(0, int'(r1))});
      check({tag, "_a_busy2"}, {63'd0, a_b2}, {63'd0, exp_busy(0, int'(r2))});
      check({tag, "_b_out1"}, {32'd0, b_out1}, exp_out(1, int'(r1)));
      check({tag, "_b_out2"}, {32'd0, b_out2}, exp_out(1, int'(r2)));
      check({tag, "_b_busy1"}, {63'd0, b_b1}, {63'd0, exp_busy(1, int'(r1))});
      check({tag, "_b_busy2"}, {63'd0, b_b2}, {63'd0, exp_busy(1, int'(r2))});
   endtask

   // One clock: check the combinational view, take the edge, update the model, drop strobes.
   task automatic cycle(input string tag);
      #1 check_all(tag);
      @(posedge clk);
      model_edge();
      #1;
      we    = 1'b0;
      iv    = 1'b0;
      flush = 1'b0;
   endtask

   task automatic reset_pulse(input string tag);
      #2 rst_n = 1'b0;
      #1 check_all(tag);
      model_clear();
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic do_write(input logic [4:0] a, input logic [63:0] d, input logic [7:0] m);
      we    = 1'b1;
      waddr = a;
      wdata = d;
      wmask = m;
   endtask

   initial begin
      rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; wmask = '0;
      r1 = '0; r2 = '0; iv = 1'b0; ia = '0; flush = 1'b0;
      model_clear();
      @(posedge clk);
      #1 check_all("in_reset");
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Every address reads zero and idle after reset.
      for (int r = 0; r < 32; r++) begin
         r1 = 5'(r);
         r2 = 5'(31 - r);
         cycle("post_reset");
      end

      // Full write then plain read.
      do_write(5'd5, 64'h1122334455667788, 8'hFF);
      r1 = 5'd5;
      cycle("t1_write");
      r1 = 5'd5;
      #1 check("t1_r5", a_out1, 64'h1122334455667788);
      cycle("t1_read");

      // Byte-masked write with same-cycle merged bypass.
      do_write(5'd7, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
      cycle("t2_fill");
      do_write(5'd7, 64'h0000_0000_0000_00BB, 8'h01);
      r1 = 5'd7;
      #1 check("t2_bypass", a_out1, 64'hAAAA_AAAA_AAAA_AABB);
      cycle("t2_merge");
      r1 = 5'd7;
      cycle("t2_after");

      r1 = 5'd5;
      reset_pulse("rst_mid");

      // Partial write to an invalid register zero-fills; register 0 stays zero.
      do_write(5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 8'hF0);
      cycle("t3_write");
      r1 = 5'd9;
      #1 check("t3_r9", a_out1, 64'hFFFF_FFFF_0000_0000);
      cycle("t3_read");
      do_write(5'd0, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
      r1 = 5'd0;
      #1 check("t3_r0_bypass", a_out1, 64'd0);
      cycle("t3_r0_write");
      r1 = 5'd0;
      cycle("t3_r0_read");

      // Issue sets busy; writeback bypasses it; same-cycle issue wins over writeback.
      iv = 1'b1; ia = 5'd3;
      cycle("t4_issue");
      r1 = 5'd3;
      #1 check("t4_busy_set", {63'd0, a_b1}, 64'd1);
      do_write(5'd3, 64'h0123_4567_89AB_CDEF, 8'hFF);
      #1 check("t4_wb_bypass", {63'd0, a_b1}, 64'd0);
      cycle("t4_wb");
      do_write(5'd3, 64'h55, 8'h01);
      iv = 1'b1; ia = 5'd3; r1 = 5'd3;
      cycle("t4_issue_wb");
      r1 = 5'd3;
      #1 check("t4_set_beats_clr", {63'd0, a_b1}, 64'd1);
      cycle("t4_after");

      // Flush overrides a coincident issue.
      iv = 1'b1; ia = 5'd2; cycle("t5_i2");
      iv = 1'b1; ia = 5'd4; cycle("t5_i4");
      iv = 1'b1; ia = 5'd6; cycle("t5_i6");
      r1 = 5'd2; r2 = 5'd4;
      #1 check("t5_busy2", {63'd0, a_b1}, 64'd1);
      check("t5_busy4", {63'd0, a_b2}, 64'd1);
      flush = 1'b1; iv = 1'b1; ia = 5'd8; r1 = 5'd6;
      cycle("t5_flush");
      r1 = 5'd8; r2 = 5'd6;
      #1 check("t5_r8_clear", {63'd0, a_b1}, 64'd0);
      check("t5_r6_clear", {63'd0, a_b2}, 64'd0);
      cycle("t5_after");
      iv = 1'b1; ia = 5'd2; cycle("t5_reissue");
      r1 = 5'd2; r2 = 5'd3;
      reset_pulse("t5_rst");

      // Out-of-range address on the 20-entry instance is ignored.
      do_write(5'd25, 64'h1234_5678_9ABC_DEF0, 8'hFF);
      r1 = 5'd25;
      #1 check("t6_b_bypass25", {32'd0, b_out1}, 64'd0);
      cycle("t6_write25");
      r1 = 5'd25;
      #1 check("t6_b_read25", {32'd0, b_out1}, 64'd0);
      for (int r = 0; r < 20; r++) begin
         r1 = 5'(r);
         r2 = 5'(19 - r);
         cycle("t6_scan");
      end

      // Randomised traffic on both instances.
      for (int n = 0; n < 400; n++) begin
         we    = 1'($urandom_range(0, 1));
         waddr = 5'($urandom_range(0, 31));
         wdata = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0:       wmask = 8'hFF;
            1:       wmask = 8'h00;
            default: wmask = 8'($urandom);
         endcase
         r1    = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31));
         r2    = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
         iv    = 1'($urandom_range(0, 1));
         ia    = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
         flush = ($urandom_range(0, 15) == 0);
         cycle("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
